// File: rtl/jg_vote_collector.sv
// rtl/jg_vote_collector.sv - synchronised, debounced three-judge vote collector with a timed round FSM
// Optional macro JG_EARLY_CLOSE_EN closes the voting window as soon as all three votes are in.
module jg_vote_collector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] btn,
  output logic [2:0] abc,
  output logic       abc_valid,
  output logic       busy,
  output logic       round_done
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [2:0]    r_sync1, r_sync2, r_deb, r_deb_q, r_vote, r_abc;
  logic [DW-1:0] r_dcnt [3];
  logic [1:0]    r_state;
  logic [WW-1:0] r_wcnt;
  logic [HW-1:0] r_hcnt;
  logic [2:0]    w_rise, w_vote_next;
  logic          w_close, w_hold_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_q <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == D_LAST) begin
          r_deb[i]  <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_rise      = r_deb & ~r_deb_q;
  assign w_vote_next = r_vote | w_rise;
  assign w_hold_last = (r_hcnt == H_LAST);
`ifdef JG_EARLY_CLOSE_EN
  assign w_close     = (r_wcnt == W_LAST) || (r_vote == 3'b111);
`else
  assign w_close     = (r_wcnt == W_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vote  <= '0;
      r_abc   <= '0;
      r_wcnt  <= '0;
      r_hcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vote  <= '0;
            r_wcnt  <= '0;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_vote <= w_vote_next;
          if (w_close) begin
            r_abc   <= w_vote_next;
            r_hcnt  <= '0;
            r_state <= S_HOLD;
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
          end
        end
        S_HOLD: begin
          if (w_hold_last) r_state <= S_IDLE;
          else r_hcnt <= r_hcnt + HW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign abc        = r_abc;
  assign abc_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign round_done = abc_valid && w_hold_last;
endmodule
